regfile_seq: RTL and testbench

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regseq_pkg.sv | 26 ++
 rtl/regfile_seq_if.sv | 36 +++
 rtl/regfile_seq.sv | 166 ++++++++++++++++
 tb/tb_regfile_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regseq_pkg.sv
// Shared types and default sizes for the sequenced register-file controller.
package regseq_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 3;

    typedef enum logic [2:0] {
        OP_LDI    = 3'b000,
        OP_MOV    = 3'b001,
        OP_ADD    = 3'b010,
        OP_RD     = 3'b011,
        OP_CLRALL = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    // Codes 101..111 are reserved and raise ERR.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

endpackage

// File: rtl/regfile_seq_if.sv
// Command, register-file and result signals between the sequencer and its environment.
import regseq_pkg::*;

interface regfile_seq_if #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [2:0]    CMD_OP;
    logic [AW-1:0] CMD_RD;
    logic [AW-1:0] CMD_RS;
    logic [AW-1:0] CMD_RT;
    logic [DW-1:0] CMD_IMM;
    logic [AW-1:0] RP;
    logic [AW-1:0] RQ;
    logic [AW-1:0] WA;
    logic          WR;
    logic [DW-1:0] LD_DATA;
    logic [DW-1:0] DATAP;
    logic [DW-1:0] DATAQ;
    logic          RES_VALID;
    logic [DW-1:0] RES_DATA;
    logic          ERR;

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_RD, CMD_RS, CMD_RT, CMD_IMM, DATAP, DATAQ,
        output CMD_READY, RP, RQ, WA, WR, LD_DATA, RES_VALID, RES_DATA, ERR
    );

    modport master (
        output CMD_VALID, CMD_OP, CMD_RD, CMD_RS, CMD_RT, CMD_IMM, DATAP, DATAQ,
        input  CMD_READY, RP, RQ, WA, WR, LD_DATA, RES_VALID, RES_DATA, ERR
    );

endinterface

// File: rtl/regfile_seq.sv
// Command sequencer driving an external register file: LDI/MOV/ADD/RD in two cycles, CLRALL sweep.
// Define REGSEQ_CARRY_EN to add the registered ADD carry-out port CARRY.
import regseq_pkg::*;

module regfile_seq #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic         CLK,
    input  logic         CLR,
    regfile_seq_if.slave bus
`ifdef REGSEQ_CARRY_EN
    ,
    output logic         CARRY
`endif
);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs_q, rs_d;
    logic [AW-1:0] rt_q, rt_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] rq_q, rq_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic          wr_raw;
    logic [DW-1:0] ld_data;
`ifdef REGSEQ_CARRY_EN
    logic          carry_q, carry_d;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            imm_q       <= '0;
            rp_q        <= '0;
            rq_q        <= '0;
            wa_q        <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef REGSEQ_CARRY_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            imm_q       <= imm_d;
            rp_q        <= rp_d;
            rq_q        <= rq_d;
            wa_q        <= wa_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
`ifdef REGSEQ_CARRY_EN
            carry_q     <= carry_d;
`endif
        end
    end

    // rp_d/rq_d/wa_d double as the live address outputs, so IDLE holds the last address.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        imm_d       = imm_q;
        rp_d        = rp_q;
        rq_d        = rq_q;
        wa_d        = wa_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;
        wr_raw      = 1'b0;
        ld_data     = '0;
`ifdef REGSEQ_CARRY_EN
        carry_d     = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.CMD_VALID) begin
                    op_d  = bus.CMD_OP;
                    rd_d  = bus.CMD_RD;
                    rs_d  = bus.CMD_RS;
                    rt_d  = bus.CMD_RT;
                    imm_d = bus.CMD_IMM;
                    if (!op_legal(bus.CMD_OP)) begin
                        err_d = 1'b1;
                    end else if (bus.CMD_OP == OP_CLRALL) begin
                        state_d = ST_SWEEP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                rp_d    = rs_q;
                rq_d    = rt_q;
                wa_d    = rd_q;
                state_d = ST_IDLE;
                case (op_q)
                    OP_LDI: begin
                        wr_raw  = 1'b1;
                        ld_data = imm_q;
                    end
                    OP_MOV: begin
                        wr_raw  = 1'b1;
                        ld_data = bus.DATAP;
                    end
                    OP_ADD: begin
                        wr_raw  = 1'b1;
`ifdef REGSEQ_CARRY_EN
                        {carry_d, ld_data} = {1'b0, bus.DATAP} + {1'b0, bus.DATAQ};
`else
                        ld_data = bus.DATAP + bus.DATAQ;
`endif
                    end
                    OP_RD: begin
                        res_data_d  = bus.DATAP;
                        res_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_SWEEP: begin
                wr_raw = 1'b1;
                wa_d   = cnt_q;
                cnt_d  = cnt_q + AW'(1);
                if (&cnt_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.CMD_READY = (state_q == ST_IDLE);
    assign bus.RP        = rp_d;
    assign bus.RQ        = rq_d;
    assign bus.WA        = wa_d;
    // A CLR cycle never writes, even mid-EXEC or mid-sweep.
    assign bus.WR        = wr_raw & ~CLR;
    assign bus.LD_DATA   = ld_data;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.ERR       = err_q;
`ifdef REGSEQ_CARRY_EN
    assign CARRY         = carry_q;
`endif

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 8x4 register file attached.
module tb_regfile_seq;
    import regseq_pkg::*;

    localparam int DW   = 4;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   w;
    logic [DW-1:0] rf [NREG] = '{default: '0};
`ifdef REGSEQ_CARRY_EN
    logic carry;
`endif

    regfile_seq_if #(.DW(DW), .AW(AW)) bus ();

    regfile_seq #(.DW(DW), .AW(AW)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
`ifdef REGSEQ_CARRY_EN
        ,
        .CARRY (carry)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (bus.WR) rf[bus.WA] <= bus.LD_DATA;
    assign bus.DATAP = rf[bus.RP];
    assign bus.DATAQ = rf[bus.RQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command, wait (bounded) for acceptance; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] op, input int rd, input int rs, input int rt,
                        input int imm, output int waited);
        bus.CMD_OP    = op;
        bus.CMD_RD    = AW'(rd);
        bus.CMD_RS    = AW'(rs);
        bus.CMD_RT    = AW'(rt);
        bus.CMD_IMM   = DW'(imm);
        bus.CMD_VALID = 1'b1;
        waited = 0;
        while (!bus.CMD_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=%0d expected=<20", waited);
        end
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic ldi(input int r, input int v);
        int ww;
        send(OP_LDI, r, 0, 0, v, ww);
        @(negedge CLK);
    endtask

    task automatic do_rd(input string tag, input int r, input logic [31:0] exp);
        int ww;
        send(OP_RD, 0, r, 0, 0, ww);
        chk({tag, "_wr"}, bus.WR, 0);
        chk({tag, "_rp"}, bus.RP, r);
        @(negedge CLK);
        chk({tag, "_vld"}, bus.RES_VALID, 1);
        chk({tag, "_data"}, bus.RES_DATA, exp);
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = '0;
        bus.CMD_RD    = '0;
        bus.CMD_RS    = '0;
        bus.CMD_RT    = '0;
        bus.CMD_IMM   = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", bus.CMD_READY, 1);
        chk("rst_wr", bus.WR, 0);
        chk("rst_res_valid", bus.RES_VALID, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_res_data", bus.RES_DATA, 0);
        chk("rst_addr", {bus.RP, bus.RQ, bus.WA}, 0);
        CLR = 1'b0;
        @(negedge CLK);

        // LDI R3=A then RD R3
        send(OP_LDI, 3, 0, 0, 'hA, w);
        chk("ldi_wr", bus.WR, 1);
        chk("ldi_wa", bus.WA, 3);
        chk("ldi_data", bus.LD_DATA, 'hA);
        chk("ldi_ready_low", bus.CMD_READY, 0);
        @(negedge CLK);
        chk("ldi_idle_wr", bus.WR, 0);
        chk("ldi_idle_ready", bus.CMD_READY, 1);
        do_rd("rd_r3", 3, 'hA);
        @(negedge CLK);
        chk("rd_pulse_end", bus.RES_VALID, 0);
        chk("rd_hold", bus.RES_DATA, 'hA);

        // ADD with carry out: 9 + 8 = 0x11 -> 1, carry 1
        ldi(1, 9);
        ldi(2, 8);
        send(OP_ADD, 4, 1, 2, 0, w);
        chk("add_wr", bus.WR, 1);
        chk("add_wa", bus.WA, 4);
        chk("add_rq", bus.RQ, 2);
        chk("add_data", bus.LD_DATA, 1);
        @(negedge CLK);
`ifdef REGSEQ_CARRY_EN
        chk("add_carry", carry, 1);
`endif
        do_rd("rd_r4", 4, 1);

        // ADD R1=R1+R1 uses pre-write value: 9+9 = 0x12 -> 2
        send(OP_ADD, 1, 1, 1, 0, w);
        chk("add_self_data", bus.LD_DATA, 2);
        @(negedge CLK);
        do_rd("rd_r1", 1, 2);

        // MOV R5=R3
        send(OP_MOV, 5, 3, 0, 0, w);
        chk("mov_data", bus.LD_DATA, 'hA);
        @(negedge CLK);
        do_rd("rd_r5", 5, 'hA);
        @(negedge CLK);

        // Back-to-back with CMD_VALID held high
        bus.CMD_OP = OP_LDI; bus.CMD_RD = 3'd5; bus.CMD_IMM = 4'd1; bus.CMD_VALID = 1'b1;
        @(negedge CLK);
        chk("b2b0_ready", bus.CMD_READY, 0);
        chk("b2b0_wa", bus.WA, 5);
        chk("b2b0_data", bus.LD_DATA, 1);
        bus.CMD_RD = 3'd6; bus.CMD_IMM = 4'd2;
        @(negedge CLK);
        chk("b2b_gap_wr", bus.WR, 0);
        chk("b2b_gap_ready", bus.CMD_READY, 1);
        @(negedge CLK);
        chk("b2b1_wr", bus.WR, 1);
        chk("b2b1_wa", bus.WA, 6);
        chk("b2b1_data", bus.LD_DATA, 2);
        bus.CMD_OP = OP_ADD; bus.CMD_RD = 3'd7; bus.CMD_RS = 3'd5; bus.CMD_RT = 3'd6;
        @(negedge CLK);
        chk("b2b_gap2_wr", bus.WR, 0);
        @(negedge CLK);
        chk("b2b2_wa", bus.WA, 7);
        chk("b2b2_data", bus.LD_DATA, 3);
        bus.CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b_end_ready", bus.CMD_READY, 1);
        @(negedge CLK);
        chk("b2b_no_dup_wr", bus.WR, 0);
`ifdef REGSEQ_CARRY_EN
        chk("b2b_carry0", carry, 0);
`endif
        chk("b2b_r7", rf[7], 3);

        // Illegal opcode 110
        send(3'b110, 2, 0, 0, 'hF, w);
        chk("ill_err", bus.ERR, 1);
        chk("ill_wr", bus.WR, 0);
        chk("ill_ready", bus.CMD_READY, 1);
        send(OP_LDI, 0, 0, 0, 5, w);
        chk("ill_next_wait", w, 0);
        chk("ill_next_wr", bus.WR, 1);
        chk("ill_next_wa", bus.WA, 0);
        chk("ill_err_once", bus.ERR, 0);
        @(negedge CLK);
        chk("ill_no_write", rf[2], 8);

        // Full CLRALL sweep
        for (int i = 0; i < NREG; i++) ldi(i, i + 1);
        send(OP_CLRALL, 0, 0, 0, 0, w);
        for (int k = 0; k < NREG; k++) begin
            chk("sweep_ready", bus.CMD_READY, 0);
            chk("sweep_wr", bus.WR, 1);
            chk("sweep_wa", bus.WA, k);
            chk("sweep_data", bus.LD_DATA, 0);
            @(negedge CLK);
        end
        chk("sweep_done_ready", bus.CMD_READY, 1);
        chk("sweep_done_wr", bus.WR, 0);
        for (int i = 0; i < NREG; i++) chk("sweep_rf_zero", rf[i], 0);
        do_rd("rd_after_clr", 5, 0);
        @(negedge CLK);

        // CLR in the fourth sweep cycle (WA=3) aborts the sweep
        for (int i = 0; i < NREG; i++) ldi(i, i + 1);
        send(OP_CLRALL, 0, 0, 0, 0, w);
        repeat (3) @(negedge CLK);
        chk("abort_wa", bus.WA, 3);
        CLR = 1'b1;
        #1;
        chk("abort_wr_gated", bus.WR, 0);
        @(negedge CLK);
        CLR = 1'b0;
        chk("abort_ready", bus.CMD_READY, 1);
        chk("abort_res_data", bus.RES_DATA, 0);
        @(negedge CLK);
        chk("abort_wr_after", bus.WR, 0);
        for (int i = 0; i < 3; i++) chk("abort_cleared", rf[i], 0);
        for (int i = 3; i < NREG; i++) chk("abort_kept", rf[i], i + 1);
        do_rd("rd_r3_kept", 3, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
